// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interrupt controller: CSR addresses,
// mcause codes, mstatus bit positions, FSM state encoding and mstatus update helpers.
package clint_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_SAVE_MEPC    = 3'd1,
    ST_SAVE_MCAUSE  = 3'd2,
    ST_SAVE_MSTATUS = 3'd3,
    ST_MRET_MSTATUS = 3'd4,
    ST_JUMP         = 3'd5
  } state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_IRQ    = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  // Trap entry: stash MIE into MPIE and disable interrupts.
  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] m);
    logic [31:0] r;
    r           = m;
    r[MPIE_BIT] = m[MIE_BIT];
    r[MIE_BIT]  = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] m);
    logic [31:0] r;
    r           = m;
    r[MIE_BIT]  = m[MPIE_BIT];
    r[MPIE_BIT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/clint_if.sv
// Connection bundle between the pipeline/CSR file (master) and the clint (slave).
interface clint_if;

  logic [31:0] instAddr;
  logic        ecall;
  logic        ebreak;
  logic        mret;
  logic        irq;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] mstatus;
  logic        clintWriteEn;
  logic [11:0] clintAddr;
  logic [31:0] clintWriteData;
  logic        holdEn;
  logic        jumpEn;
  logic [31:0] jumpAddr;

  modport master (
    output instAddr, ecall, ebreak, mret, irq, mtvec, mepc, mstatus,
    input  clintWriteEn, clintAddr, clintWriteData, holdEn, jumpEn, jumpAddr
  );

  modport slave (
    input  instAddr, ecall, ebreak, mret, irq, mtvec, mepc, mstatus,
    output clintWriteEn, clintAddr, clintWriteData, holdEn, jumpEn, jumpAddr
  );

endinterface

// File: rtl/clint_timer.sv
// Free-running timer for the clint: counts 0..TIMER_PERIOD-1 and raises a
// pending flag on every wrap, held until the timer trap is taken.
module clint_timer #(
  parameter logic [31:0] TIMER_PERIOD = 32'd100000
) (
  input  logic clk,
  input  logic rstn,
  input  logic take,
  output logic pending
);

  logic [31:0] count;
  logic        wrap;

  assign wrap = (count == TIMER_PERIOD - 32'd1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count   <= 32'd0;
      pending <= 1'b0;
    end else begin
      count <= wrap ? 32'd0 : count + 32'd1;
      // A fresh wrap wins over a same-cycle acknowledge so no request is lost.
      if (wrap)
        pending <= 1'b1;
      else if (take)
        pending <= 1'b0;
    end
  end

endmodule

// File: rtl/clint.sv
// Core-local interrupt/trap controller: sequences mepc/mcause/mstatus writes and
// redirects the PC on traps and mret. Optional timer source enabled by CLINT_TIMER_EN.
module clint
  import clint_pkg::*;
#(
  parameter logic [31:0] TIMER_PERIOD = 32'd100000
) (
  input  logic    clk,
  input  logic    rstn,
  clint_if.slave  bus
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] saved_pc;
  logic [31:0] saved_cause;
  logic        is_mret;

  logic        idle;
  logic        mie;
  logic        take_irq;
  logic        take_timer;
  logic        mret_req;
  logic        trap_req;
  logic        trigger;
  logic [31:0] cause;
  logic        timer_pending;

`ifdef CLINT_TIMER_EN
  logic timer_take;

  assign timer_take = idle & ~bus.ecall & ~bus.ebreak & ~bus.mret & ~take_irq & take_timer;

  clint_timer #(.TIMER_PERIOD(TIMER_PERIOD)) u_timer (
    .clk     (clk),
    .rstn    (rstn),
    .take    (timer_take),
    .pending (timer_pending)
  );
`else
  assign timer_pending = 1'b0 & (TIMER_PERIOD == 32'd0);
`endif

  assign idle       = (state == ST_IDLE);
  assign mie        = bus.mstatus[MIE_BIT];
  assign take_irq   = bus.irq & mie;
  assign take_timer = timer_pending & mie;

  // Priority ecall > ebreak > mret > irq > timer.
  assign mret_req = ~bus.ecall & ~bus.ebreak & bus.mret;
  assign trap_req = bus.ecall | bus.ebreak | (~bus.mret & (take_irq | take_timer));
  assign trigger  = idle & (trap_req | mret_req);

  always_comb begin
    cause = CAUSE_TIMER;
    if (bus.ecall)       cause = CAUSE_ECALL;
    else if (bus.ebreak) cause = CAUSE_EBREAK;
    else if (take_irq)   cause = CAUSE_IRQ;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      saved_pc    <= 32'd0;
      saved_cause <= 32'd0;
      is_mret     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (trigger) begin
        is_mret <= ~trap_req;
        if (trap_req) begin
          saved_pc    <= bus.instAddr;
          saved_cause <= cause;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (trap_req)      state_nxt = ST_SAVE_MEPC;
        else if (mret_req) state_nxt = ST_MRET_MSTATUS;
      end
      ST_SAVE_MEPC:    state_nxt = ST_SAVE_MCAUSE;
      ST_SAVE_MCAUSE:  state_nxt = ST_SAVE_MSTATUS;
      ST_SAVE_MSTATUS: state_nxt = ST_JUMP;
      ST_MRET_MSTATUS: state_nxt = ST_JUMP;
      ST_JUMP:         state_nxt = ST_IDLE;
      default:         state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.clintWriteEn   = 1'b0;
    bus.clintAddr      = 12'd0;
    bus.clintWriteData = 32'd0;
    bus.jumpEn         = 1'b0;
    bus.jumpAddr       = 32'd0;
    bus.holdEn         = ~idle | trigger;
    case (state)
      ST_SAVE_MEPC: begin
        bus.clintWriteEn   = 1'b1;
        bus.clintAddr      = CSR_MEPC;
        bus.clintWriteData = saved_pc;
      end
      ST_SAVE_MCAUSE: begin
        bus.clintWriteEn   = 1'b1;
        bus.clintAddr      = CSR_MCAUSE;
        bus.clintWriteData = saved_cause;
      end
      ST_SAVE_MSTATUS: begin
        bus.clintWriteEn   = 1'b1;
        bus.clintAddr      = CSR_MSTATUS;
        bus.clintWriteData = mstatus_on_trap(bus.mstatus);
      end
      ST_MRET_MSTATUS: begin
        bus.clintWriteEn   = 1'b1;
        bus.clintAddr      = CSR_MSTATUS;
        bus.clintWriteData = mstatus_on_mret(bus.mstatus);
      end
      ST_JUMP: begin
        bus.jumpEn   = 1'b1;
        // Direct mode only: mode bits of mtvec are dropped.
        bus.jumpAddr = is_mret ? bus.mepc : (bus.mtvec & 32'hFFFF_FFFC);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_clint.sv
// Directed self-checking bench for clint; observed outputs are packed as
// {holdEn, jumpEn, clintWriteEn, clintAddr, clintWriteData, jumpAddr}.
module tb_clint;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  clint_if bus();

  clint #(.TIMER_PERIOD(32'd10)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  function automatic logic [78:0] pk(input logic h, input logic j, input logic w,
                                     input logic [11:0] a, input logic [31:0] d,
                                     input logic [31:0] ja);
    return {h, j, w, a, d, ja};
  endfunction

  function automatic logic [78:0] obs_now();
    return {bus.holdEn, bus.jumpEn, bus.clintWriteEn, bus.clintAddr, bus.clintWriteData, bus.jumpAddr};
  endfunction

  localparam logic [78:0] ZERO = 79'd0;

  task automatic clear_inputs();
    bus.instAddr = 32'd0;
    bus.ecall    = 1'b0;
    bus.ebreak   = 1'b0;
    bus.mret     = 1'b0;
    bus.irq      = 1'b0;
    bus.mtvec    = 32'h200;
    bus.mepc     = 32'd0;
    bus.mstatus  = 32'd0;
  endtask

  task automatic test_reset();
    logic [78:0] o;
    clear_inputs();
    rstn = 1'b0;
    #1;
    o = obs_now();
    n_checks++;
    if (o !== ZERO) begin n_fail++; $display("FAIL reset_t0: got %h want %h", o, ZERO); end
    repeat (2) @(negedge clk);
    o = obs_now();
    n_checks++;
    if (o !== ZERO) begin n_fail++; $display("FAIL reset_held: got %h want %h", o, ZERO); end
    rstn = 1'b1;
  endtask

  task automatic test_ecall();
    logic [78:0] e [6];
    logic [78:0] o;
    e[0] = pk(1'b1, 1'b0, 1'b0, 12'h0,   32'h0,   32'h0);
    e[1] = pk(1'b1, 1'b0, 1'b1, 12'h341, 32'h100, 32'h0);
    e[2] = pk(1'b1, 1'b0, 1'b1, 12'h342, 32'd11,  32'h0);
    e[3] = pk(1'b1, 1'b0, 1'b1, 12'h300, 32'h80,  32'h0);
    e[4] = pk(1'b1, 1'b1, 1'b0, 12'h0,   32'h0,   32'h200);
    e[5] = ZERO;
    @(negedge clk);
    bus.instAddr = 32'h100; bus.mtvec = 32'h200; bus.mstatus = 32'h8; bus.ecall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) bus.ecall = 1'b0;
      #1;
      o = obs_now();
      n_checks++;
      if (o !== e[i]) begin n_fail++; $display("FAIL ecall_c%0d: got %h want %h", i, o, e[i]); end
    end
  endtask

  task automatic test_mret();
    logic [78:0] e [4];
    logic [78:0] o;
    e[0] = pk(1'b1, 1'b0, 1'b0, 12'h0,   32'h0,  32'h0);
    e[1] = pk(1'b1, 1'b0, 1'b1, 12'h300, 32'h88, 32'h0);
    e[2] = pk(1'b1, 1'b1, 1'b0, 12'h0,   32'h0,  32'h104);
    e[3] = ZERO;
    @(negedge clk);
    bus.mepc = 32'h104; bus.mstatus = 32'h80; bus.mret = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) bus.mret = 1'b0;
      #1;
      o = obs_now();
      n_checks++;
      if (o !== e[i]) begin n_fail++; $display("FAIL mret_c%0d: got %h want %h", i, o, e[i]); end
    end
  endtask

  task automatic test_irq();
    logic [78:0] e [6];
    logic [78:0] o;
    @(negedge clk);
    bus.mstatus = 32'h0; bus.irq = 1'b1; bus.instAddr = 32'h300;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      o = obs_now();
      n_checks++;
      if (o !== ZERO) begin n_fail++; $display("FAIL irq_masked_c%0d: got %h want %h", i, o, ZERO); end
    end
    e[0] = pk(1'b1, 1'b0, 1'b0, 12'h0,   32'h0,         32'h0);
    e[1] = pk(1'b1, 1'b0, 1'b1, 12'h341, 32'h300,       32'h0);
    e[2] = pk(1'b1, 1'b0, 1'b1, 12'h342, 32'h8000_000B, 32'h0);
    e[3] = pk(1'b1, 1'b0, 1'b1, 12'h300, 32'h80,        32'h0);
    e[4] = pk(1'b1, 1'b1, 1'b0, 12'h0,   32'h0,         32'h200);
    e[5] = ZERO;
    @(negedge clk);
    bus.mstatus = 32'h8;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) bus.irq = 1'b0;
      #1;
      o = obs_now();
      n_checks++;
      if (o !== e[i]) begin n_fail++; $display("FAIL irq_trap_c%0d: got %h want %h", i, o, e[i]); end
    end
  endtask

  task automatic test_ecall_irq();
    logic [78:0] e [7];
    logic [78:0] o;
    e[0] = pk(1'b1, 1'b0, 1'b0, 12'h0,   32'h0,   32'h0);
    e[1] = pk(1'b1, 1'b0, 1'b1, 12'h341, 32'h400, 32'h0);
    e[2] = pk(1'b1, 1'b0, 1'b1, 12'h342, 32'd11,  32'h0);
    e[3] = pk(1'b1, 1'b0, 1'b1, 12'h300, 32'h80,  32'h0);
    e[4] = pk(1'b1, 1'b1, 1'b0, 12'h0,   32'h0,   32'h200);
    e[5] = ZERO;
    e[6] = ZERO;
    @(negedge clk);
    bus.instAddr = 32'h400; bus.mstatus = 32'h8; bus.ecall = 1'b1; bus.irq = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) bus.ecall = 1'b0;
      if (i == 4) bus.mstatus = 32'h80;
      #1;
      o = obs_now();
      n_checks++;
      if (o !== e[i]) begin n_fail++; $display("FAIL ecall_irq_c%0d: got %h want %h", i, o, e[i]); end
    end
    bus.irq = 1'b0;
    bus.mstatus = 32'h8;
  endtask

  task automatic test_reset_mid();
    logic [78:0] e [6];
    logic [78:0] o;
    @(negedge clk);
    bus.instAddr = 32'h500; bus.mstatus = 32'h8; bus.ecall = 1'b1;
    #1;
    o = obs_now();
    n_checks++;
    if (o !== pk(1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0)) begin
      n_fail++; $display("FAIL rmid_c0: got %h want hold only", o);
    end
    @(negedge clk);
    bus.ecall = 1'b0;
    #1;
    o = obs_now();
    n_checks++;
    if (o !== pk(1'b1, 1'b0, 1'b1, 12'h341, 32'h500, 32'h0)) begin
      n_fail++; $display("FAIL rmid_c1: got %h want mepc write 500", o);
    end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    o = obs_now();
    n_checks++;
    if (o !== ZERO) begin n_fail++; $display("FAIL rmid_async: got %h want %h", o, ZERO); end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    o = obs_now();
    n_checks++;
    if (o !== ZERO) begin n_fail++; $display("FAIL rmid_release: got %h want %h", o, ZERO); end
    e[0] = pk(1'b1, 1'b0, 1'b0, 12'h0,   32'h0,   32'h0);
    e[1] = pk(1'b1, 1'b0, 1'b1, 12'h341, 32'h600, 32'h0);
    e[2] = pk(1'b1, 1'b0, 1'b1, 12'h342, 32'd11,  32'h0);
    e[3] = pk(1'b1, 1'b0, 1'b1, 12'h300, 32'h80,  32'h0);
    e[4] = pk(1'b1, 1'b1, 1'b0, 12'h0,   32'h0,   32'h200);
    e[5] = ZERO;
    @(negedge clk);
    bus.instAddr = 32'h600; bus.ecall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) bus.ecall = 1'b0;
      #1;
      o = obs_now();
      n_checks++;
      if (o !== e[i]) begin n_fail++; $display("FAIL rmid_rerun_c%0d: got %h want %h", i, o, e[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [78:0] e [11];
    logic [78:0] o;
    e[0]  = pk(1'b1, 1'b0, 1'b0, 12'h0,   32'h0,   32'h0);
    e[1]  = pk(1'b1, 1'b0, 1'b1, 12'h341, 32'h700, 32'h0);
    e[2]  = pk(1'b1, 1'b0, 1'b1, 12'h342, 32'd11,  32'h0);
    e[3]  = pk(1'b1, 1'b0, 1'b1, 12'h300, 32'h80,  32'h0);
    e[4]  = pk(1'b1, 1'b1, 1'b0, 12'h0,   32'h0,   32'h200);
    e[5]  = pk(1'b1, 1'b0, 1'b0, 12'h0,   32'h0,   32'h0);
    e[6]  = pk(1'b1, 1'b0, 1'b1, 12'h341, 32'h704, 32'h0);
    e[7]  = pk(1'b1, 1'b0, 1'b1, 12'h342, 32'd3,   32'h0);
    e[8]  = pk(1'b1, 1'b0, 1'b1, 12'h300, 32'h80,  32'h0);
    e[9]  = pk(1'b1, 1'b1, 1'b0, 12'h0,   32'h0,   32'h200);
    e[10] = ZERO;
    @(negedge clk);
    bus.instAddr = 32'h700; bus.mstatus = 32'h8; bus.ecall = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) bus.ecall = 1'b0;
      if (i == 4) begin bus.ebreak = 1'b1; bus.instAddr = 32'h704; end
      if (i == 6) bus.ebreak = 1'b0;
      #1;
      o = obs_now();
      n_checks++;
      if (o !== e[i]) begin n_fail++; $display("FAIL b2b_c%0d: got %h want %h", i, o, e[i]); end
    end
  endtask

`ifdef CLINT_TIMER_EN
  task automatic test_timer();
    logic [78:0] e [6];
    logic [78:0] o;
    int          waited;
    @(negedge clk);
    rstn = 1'b0;
    clear_inputs();
    bus.mstatus = 32'h8; bus.instAddr = 32'h800;
    @(negedge clk);
    rstn = 1'b1;
    waited = 0;
    while (!bus.holdEn && waited < 30) begin
      @(negedge clk);
      #1;
      waited++;
    end
    n_checks++;
    if (waited !== 10) begin n_fail++; $display("FAIL timer_latency: got %0d cycles want 10", waited); end
    e[0] = pk(1'b1, 1'b0, 1'b0, 12'h0,   32'h0,         32'h0);
    e[1] = pk(1'b1, 1'b0, 1'b1, 12'h341, 32'h800,       32'h0);
    e[2] = pk(1'b1, 1'b0, 1'b1, 12'h342, 32'h8000_0007, 32'h0);
    e[3] = pk(1'b1, 1'b0, 1'b1, 12'h300, 32'h80,        32'h0);
    e[4] = pk(1'b1, 1'b1, 1'b0, 12'h0,   32'h0,         32'h200);
    e[5] = ZERO;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      o = obs_now();
      n_checks++;
      if (o !== e[i]) begin n_fail++; $display("FAIL timer_c%0d: got %h want %h", i, o, e[i]); end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef CLINT_TIMER_EN
    test_timer();
`else
    test_ecall();
    test_mret();
    test_irq();
    test_ecall_irq();
    test_reset_mid();
    test_back_to_back();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
